// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter and its scoreboard.
// Holds the data-width default, register address width and grant encodings.
package regfile_wb_arbiter_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int REG_AW    = 5;

    typedef logic [REG_AW-1:0] regaddr_t;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_LSU = 1'b1
    } grant_e;

    // x0 is hardwired to zero, so it is never written and never pending.
    function automatic logic is_x0(input regaddr_t a);
        return (a == '0);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register, set when a load
// issues and cleared when its writeback is accepted. Bit 0 never sets.
module regfile_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREGS = DEF_NREGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_rd,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_rd,
    input  logic [REG_AW-1:0] q1_rd,
    input  logic [REG_AW-1:0] q2_rd,
    output logic              pend1,
    output logic              pend2
);

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_nxt;

    // Set is applied after clear so a new load to the same rd wins.
    always_comb begin
        pending_nxt = pending;
        for (int i = 1; i < NREGS; i++) begin
            if (clr_en && (clr_rd == REG_AW'(i))) begin
                pending_nxt[i] = 1'b0;
            end
            if (set_en && (set_rd == REG_AW'(i))) begin
                pending_nxt[i] = 1'b1;
            end
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            if (q1_rd == REG_AW'(i)) begin
                pend1 = pending[i];
            end
            if (q2_rd == REG_AW'(i)) begin
                pend2 = pending[i];
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester (ALU, LSU) round-robin arbiter onto the single register-file
// write port, with a registered write stage and a load scoreboard for decode.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    output logic              alu_ready,

    input  logic              lsu_valid,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    output logic              lsu_ready,

    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,

    input  logic              sb_set,
    input  logic [REG_AW-1:0] sb_set_rd,

    input  logic [REG_AW-1:0] q_rs1,
    input  logic [REG_AW-1:0] q_rs2,
    output logic              busy1,
    output logic              busy2
);

    grant_e            last_grant;
    grant_e            last_grant_nxt;
    logic              alu_acc;
    logic              lsu_acc;
    logic              acc_p0;
    logic              wr_p0;
    logic [REG_AW-1:0] rd_p0;
    logic [XLEN-1:0]   data_p0;

    logic              vld_p1;
    logic [REG_AW-1:0] waddr_p1;
    logic [XLEN-1:0]   wdata_p1;

    logic              pend1;
    logic              pend2;

    // Stage p0: arbitration and handshake (combinational)
    always_comb begin
        alu_ready      = 1'b0;
        lsu_ready      = 1'b0;
        last_grant_nxt = last_grant;
        if (rst_n) begin
            alu_ready = alu_valid && (!lsu_valid || (last_grant == GNT_LSU));
            lsu_ready = lsu_valid && (!alu_valid || (last_grant == GNT_ALU));
        end
        alu_acc = alu_valid && alu_ready;
        lsu_acc = lsu_valid && lsu_ready;
        if (alu_acc) begin
            last_grant_nxt = GNT_ALU;
        end else if (lsu_acc) begin
            last_grant_nxt = GNT_LSU;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= GNT_LSU;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        acc_p0  = alu_acc || lsu_acc;
        rd_p0   = alu_acc ? alu_rd : lsu_rd;
        data_p0 = alu_acc ? alu_data : lsu_data;
        wr_p0   = acc_p0 && !is_x0(rd_p0);
    end

    // Stage p1: registered write port; address/data hold between writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
        end else begin
            vld_p1 <= wr_p0;
            if (wr_p0) begin
                waddr_p1 <= rd_p0;
                wdata_p1 <= data_p0;
            end
        end
    end

    assign rf_we    = vld_p1;
    assign rf_waddr = waddr_p1;
    assign rf_wdata = wdata_p1;

    regfile_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk    (clk),
        .rst_n  (rst_n),
        .set_en (sb_set),
        .set_rd (sb_set_rd),
        .clr_en (lsu_acc),
        .clr_rd (lsu_rd),
        .q1_rd  (q_rs1),
        .q2_rd  (q_rs2),
        .pend1  (pend1),
        .pend2  (pend2)
    );

    // A write sitting in p1 is not yet visible in the register file.
    always_comb begin
        busy1 = pend1 || (vld_p1 && (waddr_p1 == q_rs1) && !is_x0(q_rs1));
        busy2 = pend2 || (vld_p1 && (waddr_p1 == q_rs2) && !is_x0(q_rs2));
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model of the arbiter rules.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, lsu_valid, alu_ready, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd, rf_waddr, sb_set_rd, q_rs1, q_rs2;
    logic [31:0] alu_data, lsu_data, rf_wdata;
    logic        rf_we, sb_set, busy1, busy2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit [31:0] m_pend;
    bit        m_last_alu;
    bit        m_we;
    bit [4:0]  m_waddr;
    bit [31:0] m_wdata;
    bit        acc_alu, acc_lsu;

    regfile_wb_arbiter #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .sb_set(sb_set), .sb_set_rd(sb_set_rd),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .busy1(busy1), .busy2(busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Both valid: the one not granted last time wins; otherwise a lone requester wins.
    function automatic bit exp_alu_gnt();
        return rst_n && alu_valid && (!lsu_valid || !m_last_alu);
    endfunction

    function automatic bit exp_lsu_gnt();
        return rst_n && lsu_valid && (!alu_valid || m_last_alu);
    endfunction

    function automatic bit exp_busy(input bit [4:0] q);
        return m_pend[q] || (m_we && (m_waddr == q) && (q != 5'd0));
    endfunction

    task automatic model_check();
        chk("alu_ready", alu_ready, exp_alu_gnt());
        chk("lsu_ready", lsu_ready, exp_lsu_gnt());
        chk("rf_we", rf_we, m_we);
        if (m_we) begin
            chk("rf_waddr", rf_waddr, m_waddr);
            chk("rf_wdata", rf_wdata, m_wdata);
        end
        chk("busy1", busy1, exp_busy(q_rs1));
        chk("busy2", busy2, exp_busy(q_rs2));
    endtask

    task automatic model_update();
        bit       ga, gl;
        bit [4:0] rd;
        ga = exp_alu_gnt();
        gl = exp_lsu_gnt();
        acc_alu = ga;
        acc_lsu = gl;
        if (!rst_n) begin
            m_pend = '0; m_last_alu = 1'b0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        end else begin
            m_we = 1'b0;
            if (ga || gl) begin
                rd = ga ? alu_rd : lsu_rd;
                m_last_alu = ga;
                if (rd != 5'd0) begin
                    m_we = 1'b1;
                    m_waddr = rd;
                    m_wdata = ga ? alu_data : lsu_data;
                end
            end
            if (gl) m_pend[lsu_rd] = 1'b0;
            if (sb_set && sb_set_rd != 5'd0) m_pend[sb_set_rd] = 1'b1;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cycle();
        sample();
        edge_step();
    endtask

    task automatic drv_alu(input bit v, input bit [4:0] rd, input bit [31:0] d);
        alu_valid = v; alu_rd = rd; alu_data = d;
    endtask

    task automatic drv_lsu(input bit v, input bit [4:0] rd, input bit [31:0] d);
        lsu_valid = v; lsu_rd = rd; lsu_data = d;
    endtask

    initial begin
        rst_n = 1'b0;
        drv_alu(1, 5'd1, 32'hAAAA_0001);
        drv_lsu(1, 5'd2, 32'hBBBB_0002);
        sb_set = 1'b0; sb_set_rd = '0; q_rs1 = '0; q_rs2 = '0;

        // Reset with both requesters active
        @(posedge clk); model_update();
        @(posedge clk); model_update(); #1;
        chk("rst_alu_ready", alu_ready, 1'b0);
        chk("rst_lsu_ready", lsu_ready, 1'b0);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_waddr", rf_waddr, 5'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        rst_n = 1'b1;

        // Three-cycle conflict after reset: ALU, LSU, ALU
        drv_alu(1, 5'd1, 32'hA1);
        drv_lsu(1, 5'd2, 32'hB2);
        sample(); chk("rr1_alu", alu_ready, 1'b1); chk("rr1_lsu", lsu_ready, 1'b0); edge_step();
        drv_alu(1, 5'd3, 32'hA3);
        sample(); chk("rr2_alu", alu_ready, 1'b0); chk("rr2_lsu", lsu_ready, 1'b1);
        chk("rr2_we", rf_we, 1'b1); chk("rr2_waddr", rf_waddr, 5'd1); chk("rr2_wdata", rf_wdata, 32'hA1);
        edge_step();
        drv_lsu(1, 5'd4, 32'hB4);
        sample(); chk("rr3_alu", alu_ready, 1'b1); chk("rr3_lsu", lsu_ready, 1'b0);
        chk("rr3_waddr", rf_waddr, 5'd2); chk("rr3_wdata", rf_wdata, 32'hB2);
        edge_step();
        drv_alu(0, 5'd0, 32'h0);
        sample(); chk("rr4_waddr", rf_waddr, 5'd3); chk("rr4_wdata", rf_wdata, 32'hA3); edge_step();
        drv_lsu(0, 5'd0, 32'h0);
        sample(); chk("rr5_waddr", rf_waddr, 5'd4); edge_step();

        // Lone ALU write, then hold of address/data on an idle cycle
        drv_alu(1, 5'd5, 32'h1234);
        sample(); chk("alu_lone_ready", alu_ready, 1'b1); edge_step();
        drv_alu(0, 5'd0, 32'h0);
        sample(); chk("alu_we", rf_we, 1'b1); chk("alu_waddr", rf_waddr, 5'd5); chk("alu_wdata", rf_wdata, 32'h1234);
        edge_step();
        sample(); chk("idle_we", rf_we, 1'b0); chk("idle_waddr_hold", rf_waddr, 5'd5);
        chk("idle_wdata_hold", rf_wdata, 32'h1234); edge_step();

        // Scoreboard: pending x7 until the load writes back
        sb_set = 1'b1; sb_set_rd = 5'd7;
        cycle();
        sb_set = 1'b0; q_rs1 = 5'd7;
        sample(); chk("sb7_busy_a", busy1, 1'b1); edge_step();
        cycle();
        drv_lsu(1, 5'd7, 32'h7777);
        sample(); chk("sb7_busy_b", busy1, 1'b1); chk("sb7_lsu_ready", lsu_ready, 1'b1); edge_step();
        drv_lsu(0, 5'd0, 32'h0);
        sample(); chk("sb7_we", rf_we, 1'b1); chk("sb7_waddr", rf_waddr, 5'd7); chk("sb7_busy_inflight", busy1, 1'b1);
        edge_step();
        sample(); chk("sb7_busy_done", busy1, 1'b0); edge_step();

        // x0 write is accepted but suppressed; x0 never becomes pending
        drv_alu(1, 5'd0, 32'hFFFF_FFFF);
        sample(); chk("x0_ready", alu_ready, 1'b1); edge_step();
        drv_alu(0, 5'd0, 32'h0);
        sb_set = 1'b1; sb_set_rd = 5'd0; q_rs2 = 5'd0;
        sample(); chk("x0_we", rf_we, 1'b0); chk("x0_busy_a", busy2, 1'b0); edge_step();
        sb_set = 1'b0;
        sample(); chk("x0_busy_b", busy2, 1'b0); edge_step();

        // Set and clear of x9 in the same cycle: set wins
        sb_set = 1'b1; sb_set_rd = 5'd9;
        drv_lsu(1, 5'd9, 32'h9999);
        sample(); chk("x9_lsu_ready", lsu_ready, 1'b1); edge_step();
        sb_set = 1'b0; drv_lsu(0, 5'd0, 32'h0); q_rs1 = 5'd9;
        cycle();
        sample(); chk("x9_still_pending", busy1, 1'b1); edge_step();

        // Reset while both are valid, with pending bits and last grant = ALU
        sb_set = 1'b1; sb_set_rd = 5'd3;
        drv_alu(1, 5'd6, 32'h6666);
        cycle();
        sb_set = 1'b0;
        rst_n = 1'b0;
        drv_alu(1, 5'd8, 32'h8888);
        drv_lsu(1, 5'd10, 32'hAAAA);
        sample(); chk("rst2_alu_ready", alu_ready, 1'b0); chk("rst2_lsu_ready", lsu_ready, 1'b0); edge_step();
        rst_n = 1'b1;
        drv_alu(0, 5'd8, 32'h8888);
        drv_lsu(0, 5'd10, 32'hAAAA);
        sample(); chk("rst2_we", rf_we, 1'b0); chk("rst2_waddr", rf_waddr, 5'd0); chk("rst2_wdata", rf_wdata, 32'd0);
        edge_step();
        for (int i = 1; i < 32; i += 2) begin
            q_rs1 = 5'(i);
            q_rs2 = 5'((i + 1) % 32);
            sample(); chk("rst2_pend1", busy1, 1'b0); chk("rst2_pend2", busy2, 1'b0); edge_step();
        end
        drv_alu(1, 5'd8, 32'h8888);
        drv_lsu(1, 5'd10, 32'hAAAA);
        sample(); chk("rst2_conf_alu", alu_ready, 1'b1); chk("rst2_conf_lsu", lsu_ready, 1'b0); edge_step();

        // Random traffic; an unaccepted request is held stable
        for (int n = 0; n < 2000; n++) begin
            if (!(alu_valid && !acc_alu)) begin
                alu_valid = ($urandom_range(0, 99) < 70);
                alu_rd    = 5'($urandom_range(0, 15));
                alu_data  = $urandom;
            end
            if (!(lsu_valid && !acc_lsu)) begin
                lsu_valid = ($urandom_range(0, 99) < 70);
                lsu_rd    = 5'($urandom_range(0, 15));
                lsu_data  = $urandom;
            end
            sb_set    = ($urandom_range(0, 99) < 30);
            sb_set_rd = 5'($urandom_range(0, 15));
            q_rs1     = 5'($urandom_range(0, 15));
            q_rs2     = 5'($urandom_range(0, 15));
            rst_n     = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter NREGS, default 32, architectural register count; address width is 5.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports alu_valid in 1, alu_rd in 5, alu_data in XLEN, alu_ready out 1: ALU writeback request.
REQ-006 SHALL have ports lsu_valid in 1, lsu_rd in 5, lsu_data in XLEN, lsu_ready out 1: load-unit writeback request.
REQ-007 SHALL have ports rf_we out 1, rf_waddr out 5, rf_wdata out XLEN: drive the register file's single write port.
REQ-008 SHALL have ports sb_set in 1, sb_set_rd in 5: mark rd pending when a load issues.
REQ-009 SHALL have ports q_rs1 in 5, q_rs2 in 5, busy1 out 1, busy2 out 1: scoreboard query for the decode stage.

Function
REQ-010 SHALL accept a transfer on a requester when valid and ready are both high in the same cycle.
REQ-011 SHALL drive ready combinationally; requester SHALL hold rd/data stable while valid high and ready low.
REQ-012 SHALL grant at most one requester per cycle; a lone valid requester is granted the same cycle.
REQ-013 SHALL, when both valid, grant the requester not granted most recently (last_grant register); max wait 1 cycle.
REQ-014 SHALL update last_grant only on an accepted transfer; last_grant reset value = LSU, so ALU wins the first conflict.
REQ-015 SHALL register the write: accepted transfer in cycle N drives rf_we=1, rf_waddr=rd, rf_wdata=data in cycle N+1 (latency 1).
REQ-016 SHALL drive rf_we=0 in any cycle following a cycle with no accepted transfer; rf_waddr/rf_wdata then hold their last value.
REQ-017 SHALL accept transfers with rd=0 (ready asserted normally) but SHALL NOT assert rf_we for them.
REQ-018 SHALL hold an NREGS-bit pending vector; bit 0 permanently 0.
REQ-019 SHALL set pending[sb_set_rd] on sb_set (ignored when sb_set_rd=0).
REQ-020 SHALL clear pending[lsu_rd] when an LSU transfer is accepted; ALU transfers do not touch pending.
REQ-021 SHALL let set win when sb_set and an accepted LSU clear target the same rd in the same cycle.
REQ-022 SHALL compute busy1 = pending[q_rs1] OR (rf_we AND rf_waddr==q_rs1 AND q_rs1!=0); same for busy2/q_rs2, combinationally.
REQ-023 SHALL accept back-to-back transfers every cycle with no bubble.

Reset
REQ-024 SHALL, on rst_n=0 at a rising edge, clear pending, set last_grant=LSU, set rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-025 SHALL drive alu_ready=0 and lsu_ready=0 while rst_n=0; a transfer presented during reset is not accepted.
REQ-026 SHALL discard a write registered in the cycle before reset (rf_we=0 in the cycle after the reset edge).

Structure
REQ-027 SHALL place XLEN default, register address width 5, and grant encodings (GNT_ALU, GNT_LSU) in the shared core package.
REQ-028 SHALL implement the pending vector as sub-module regfile_scoreboard (set/clear/two query ports); arbitration and output register stay in the top.

Verification
REQ-029 SHALL cover: ALU only, alu_rd=5, data=0x1234 -> alu_ready=1 same cycle; next cycle rf_we=1, waddr=5, wdata=0x1234.
REQ-030 SHALL cover: both valid 3 consecutive cycles after reset -> grants ALU, LSU, ALU; writes appear in that order, one per cycle.
REQ-031 SHALL cover: sb_set rd=7, then q_rs1=7 -> busy1=1 until LSU write to x7 accepted; busy1 still 1 while rf_we targets x7, 0 the cycle after.
REQ-032 SHALL cover: alu_rd=0 data=0xFFFFFFFF accepted -> rf_we stays 0; pending[0] never set by sb_set rd=0.
REQ-033 SHALL cover: sb_set rd=9 same cycle as accepted LSU write rd=9 -> pending[9]=1 afterwards.
REQ-034 SHALL cover: rst_n low for one cycle while both valid -> no ready, rf_we=0, pending all zero, next conflict grants ALU.
